max_result_monitor: RTL and testbench

- Sequential self-checking monitor for the two-operand unsigned max datapath.
- Sits beside the max unit and samples its operand pair and result.
- Computes the expected max independently, compares it against the DUT result, and counts checks and mismatches over a frame of FRAME_LEN samples.
- Reports pass/fail plus a capture of the first mismatch, so benches and on-board debug get a single verdict.

---
 rtl/max_result_monitor.sv | 139 +++++++++++++
 tb/tb_max_result_monitor.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/max_result_monitor.sv
// Self-checking monitor for a two-operand unsigned max unit: recomputes max through
// a 2-stage pipeline, counts checks/mismatches per frame and captures the first mismatch.
module max_result_monitor #(
  parameter int DATA_WIDTH = 8,
  parameter int FRAME_LEN  = 3,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  sample_valid,
  input  logic [DATA_WIDTH-1:0] number1,
  input  logic [DATA_WIDTH-1:0] number2,
  input  logic [DATA_WIDTH-1:0] result,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [CNT_WIDTH-1:0]  check_count,
  output logic [CNT_WIDTH-1:0]  error_count,
  output logic [CNT_WIDTH-1:0]  first_err_index,
  output logic [DATA_WIDTH-1:0] first_err_expected,
  output logic [DATA_WIDTH-1:0] first_err_actual
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [CNT_WIDTH-1:0] FRAME_LEN_C = CNT_WIDTH'(FRAME_LEN);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX     = '1;

  state_t                state_q;
  logic [CNT_WIDTH-1:0]  acc_q;
  logic                  s1_v_q;
  logic [DATA_WIDTH-1:0] s1_n1_q, s1_n2_q, s1_res_q;
  logic [CNT_WIDTH-1:0]  s1_idx_q;
  logic                  s2_v_q;
  logic [DATA_WIDTH-1:0] s2_exp_q, s2_res_q;
  logic [CNT_WIDTH-1:0]  s2_idx_q;
  logic [CNT_WIDTH-1:0]  chk_q, err_q, fidx_q;
  logic [DATA_WIDTH-1:0] fexp_q, fact_q;
  logic                  busy_q, done_q, pass_q;

  logic                  accept;
  logic                  mismatch;
  logic                  last_retire;
  logic [DATA_WIDTH-1:0] s1_exp;
  logic [CNT_WIDTH-1:0]  chk_d, err_d;

  always_comb begin
    accept      = (state_q == RUN) && sample_valid && (acc_q < FRAME_LEN_C);
    s1_exp      = (s1_n1_q >= s1_n2_q) ? s1_n1_q : s1_n2_q;
    mismatch    = s2_v_q && (s2_exp_q != s2_res_q);
    // The final sample retires when the frame is fully accepted and stage 1 has drained.
    last_retire = (state_q == RUN) && s2_v_q && !s1_v_q && (acc_q == FRAME_LEN_C);
    chk_d       = chk_q;
    err_d       = err_q;
    if (s2_v_q && (chk_q != CNT_MAX)) chk_d = chk_q + 1'b1;
    if (mismatch && (err_q != CNT_MAX)) err_d = err_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      s1_v_q   <= 1'b0;
      s1_n1_q  <= '0;
      s1_n2_q  <= '0;
      s1_res_q <= '0;
      s1_idx_q <= '0;
      s2_v_q   <= 1'b0;
      s2_exp_q <= '0;
      s2_res_q <= '0;
      s2_idx_q <= '0;
      chk_q    <= '0;
      err_q    <= '0;
      fidx_q   <= '0;
      fexp_q   <= '0;
      fact_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
    end else begin
      s1_v_q <= accept;
      if (accept) begin
        s1_n1_q  <= number1;
        s1_n2_q  <= number2;
        s1_res_q <= result;
        s1_idx_q <= acc_q;
        acc_q    <= acc_q + 1'b1;
      end
      s2_v_q   <= s1_v_q;
      s2_exp_q <= s1_exp;
      s2_res_q <= s1_res_q;
      s2_idx_q <= s1_idx_q;

      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q <= RUN;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            acc_q   <= '0;
            chk_q   <= '0;
            err_q   <= '0;
            fidx_q  <= '0;
            fexp_q  <= '0;
            fact_q  <= '0;
          end
        end
        RUN: begin
          chk_q <= chk_d;
          err_q <= err_d;
          if (mismatch && (err_q == '0)) begin
            fidx_q <= s2_idx_q;
            fexp_q <= s2_exp_q;
            fact_q <= s2_res_q;
          end
          if (last_retire) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (err_d == '0);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy               = busy_q;
  assign done               = done_q;
  assign pass               = pass_q;
  assign check_count        = chk_q;
  assign error_count        = err_q;
  assign first_err_index    = fidx_q;
  assign first_err_expected = fexp_q;
  assign first_err_actual   = fact_q;

endmodule

// File: tb/tb_max_result_monitor.sv
// Scoreboard bench for max_result_monitor: stimulus pushes hand-computed frame verdicts,
// a negedge monitor pops and compares them whenever done rises.
module tb_max_result_monitor;

  localparam int DW = 8;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst, start, sample_valid;
  logic [DW-1:0] number1, number2, result;
  logic          busy, done, pass;
  logic [CW-1:0] check_count, error_count, first_err_index;
  logic [DW-1:0] first_err_expected, first_err_actual;

  max_result_monitor #(.DATA_WIDTH(DW), .FRAME_LEN(3), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .sample_valid(sample_valid),
    .number1(number1), .number2(number2), .result(result),
    .busy(busy), .done(done), .pass(pass),
    .check_count(check_count), .error_count(error_count),
    .first_err_index(first_err_index),
    .first_err_expected(first_err_expected),
    .first_err_actual(first_err_actual)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned done_cyc;
    int unsigned pass_e;
    int unsigned chk_e;
    int unsigned err_e;
    int unsigned fidx_e;
    int unsigned fexp_e;
    int unsigned fact_e;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_total = 0;
  int unsigned n_pass  = 0;
  int unsigned cyc     = 0;
  int unsigned last_acc = 0;
  logic        done_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string name, int unsigned act, int unsigned exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endfunction

  // Monitor: compare the frame verdict at every rising edge of done.
  always @(negedge clk) begin
    if (done && !done_prev) begin
      chk("sb_nonempty", int'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("done_latency", cyc, e.done_cyc);
        chk("pass", pass, e.pass_e);
        chk("check_count", check_count, e.chk_e);
        chk("error_count", error_count, e.err_e);
        chk("first_err_index", first_err_index, e.fidx_e);
        chk("first_err_expected", first_err_expected, e.fexp_e);
        chk("first_err_actual", first_err_actual, e.fact_e);
      end
    end
    done_prev = done;
  end

  task automatic pulse_start();
    @(negedge clk);
    sample_valid = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send(input int unsigned a, input int unsigned b, input int unsigned r);
    @(negedge clk);
    sample_valid = 1'b1;
    number1 = DW'(a);
    number2 = DW'(b);
    result  = DW'(r);
    last_acc = cyc + 1;
  endtask

  task automatic idle(input int unsigned n);
    for (int i = 0; i < int'(n); i++) begin
      @(negedge clk);
      sample_valid = 1'b0;
    end
  endtask

  task automatic expect_frame(input int unsigned p, input int unsigned c, input int unsigned e,
                              input int unsigned fi, input int unsigned fe, input int unsigned fa);
    exp_t x;
    x.done_cyc = last_acc + 2;
    x.pass_e = p; x.chk_e = c; x.err_e = e;
    x.fidx_e = fi; x.fexp_e = fe; x.fact_e = fa;
    sb.push_back(x);
  endtask

  task automatic wait_done();
    int k = 0;
    while (!done && k < 30) begin
      @(negedge clk);
      k++;
    end
    chk("done_timeout", done, 1);
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_pass"}, pass, 0);
    chk({tag, "_check_count"}, check_count, 0);
    chk({tag, "_error_count"}, error_count, 0);
    chk({tag, "_first_err"}, first_err_index + first_err_expected + first_err_actual, 0);
  endtask

  initial begin
    logic saw_done;
    rst = 1'b1; start = 1'b0; sample_valid = 1'b0;
    number1 = '0; number2 = '0; result = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;

    // Correct DUT, back-to-back samples
    pulse_start();
    chk("busy_in_run", busy, 1);
    send(10, 20, 20); send(20, 20, 20); send(30, 20, 30);
    expect_frame(1, 3, 0, 0, 0, 0);
    idle(1); wait_done();

    // Injected errors: first at index 0
    pulse_start();
    send(10, 20, 10); send(20, 20, 20); send(30, 20, 25);
    expect_frame(0, 3, 2, 0, 20, 10);
    idle(1); wait_done();

    // Boundary values
    pulse_start();
    send(255, 0, 255); send(0, 255, 255); send(0, 0, 0);
    expect_frame(1, 3, 0, 0, 0, 0);
    idle(1); wait_done();

    // Gaps, a mid-run start, and wrong extra valids beyond the frame
    pulse_start();
    send(5, 7, 7);
    pulse_start();
    idle(1);
    send(9, 3, 9); idle(2);
    send(4, 4, 4);
    expect_frame(1, 3, 0, 0, 0, 0);
    send(1, 2, 0); send(3, 4, 0);
    idle(1); wait_done();

    // Reset aborts a frame after two accepted samples
    pulse_start();
    send(1, 1, 1);
    pulse_start();
    send(2, 3, 3);
    @(negedge clk);
    sample_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("abort");
    rst = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      saw_done = saw_done | done;
    end
    chk("abort_no_done", saw_done, 0);

    // Frame with one error at index 1, then restart straight from DONE
    pulse_start();
    send(7, 8, 8); send(100, 50, 50); send(3, 3, 3);
    expect_frame(0, 3, 1, 1, 100, 50);
    idle(1); wait_done();
    chk("hold_done", done, 1);
    pulse_start();
    chk("restart_busy", busy, 1);
    chk("restart_done", done, 0);
    chk("restart_pass", pass, 0);
    chk("restart_check_count", check_count, 0);
    chk("restart_error_count", error_count, 0);
    chk("restart_first_err", first_err_index + first_err_expected + first_err_actual, 0);
    send(200, 201, 201); send(128, 127, 128); send(0, 1, 1);
    expect_frame(1, 3, 0, 0, 0, 0);
    idle(1); wait_done();

    chk("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
